// File: rtl/demosaic_timing_ctrl.sv
// demosaic_timing_ctrl: frame/line/pixel sequencing, line-buffer control, priming mask
// and Bayer phase generation for a 3-line demosaic pipeline.
module demosaic_timing_ctrl #(
  parameter int LATENCY = 3,
  parameter int PRIME_LINES = 1,
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       cfg_pattern,
  input  logic             vs_i,
  input  logic             hs_i,
  input  logic             de_i,
  output logic             buf_aclr,
  output logic             buf_clken,
  output logic             line_phase,
  output logic             pixel_phase,
  output logic             vs_o,
  output logic             hs_o,
  output logic             de_o,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             width_err,
  output logic             frame_done
);
  typedef enum logic [1:0] {IDLE, PRIME, ACTIVE} state_t;
  state_t state;
  logic vs_q, de_q, ref_valid;
  logic [1:0] pat;
  logic [CNT_W:0] ref_width, pix_len, line_nxt;
  logic [LATENCY:1] vs_d, hs_d, de_d, mask_d;
  logic vs_rise, eol, cont, pix_max, line_max;
  always_comb begin
    vs_rise = vs_i & ~vs_q;
    eol = de_q & ~de_i;
    cont = de_i & de_q;
    pix_max = &pix_cnt;
    line_max = &line_cnt;
    pix_len = {1'b0, pix_cnt} + {{CNT_W{1'b0}}, 1'b1};
    line_nxt = {1'b0, line_cnt} + {{CNT_W{1'b0}}, 1'b1};
  end
  assign buf_aclr = vs_rise;
  assign buf_clken = de_i & (state != IDLE);
  assign vs_o = vs_d[LATENCY];
  assign hs_o = hs_d[LATENCY];
  assign de_o = de_d[LATENCY] & ~mask_d[LATENCY];
  // ACTIVE is entered on the eol that closes the last priming line, so no line is ever half-masked
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      pat <= '0;
      ref_width <= '0;
      ref_valid <= 1'b0;
      line_cnt <= '0;
      pix_cnt <= '0;
      width_err <= 1'b0;
      frame_done <= 1'b0;
      vs_d <= '0;
      hs_d <= '0;
      de_d <= '0;
      mask_d <= '0;
      line_phase <= 1'b0;
      pixel_phase <= 1'b0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
      vs_d <= {vs_d[LATENCY-1:1], vs_i};
      hs_d <= {hs_d[LATENCY-1:1], hs_i};
      de_d <= {de_d[LATENCY-1:1], de_i};
      mask_d <= {mask_d[LATENCY-1:1], state != ACTIVE};
      frame_done <= vs_rise & (state == ACTIVE || line_cnt != '0);
      line_phase <= vs_rise ? cfg_pattern[1] : line_phase ^ (de_d[LATENCY] & ~de_d[LATENCY-1]);
      pixel_phase <= (de_d[LATENCY-1] & de_d[LATENCY]) ? ~pixel_phase : pat[0];
      if (vs_rise) begin
        state <= PRIME;
        pat <= cfg_pattern;
        line_cnt <= '0;
        pix_cnt <= '0;
        width_err <= 1'b0;
        ref_valid <= 1'b0;
      end else if (state != IDLE) begin
        pix_cnt <= cont ? (pix_max ? pix_cnt : pix_len[CNT_W-1:0]) : '0;
        if (cont & pix_max) width_err <= 1'b1;
        if (eol) begin
          line_cnt <= line_max ? line_cnt : line_nxt[CNT_W-1:0];
          ref_valid <= 1'b1;
          if (!ref_valid) ref_width <= pix_len;
          else if (pix_len != ref_width) width_err <= 1'b1;
          if (state == PRIME && line_nxt >= (CNT_W+1)'(PRIME_LINES)) state <= ACTIVE;
        end
      end
    end
  end
endmodule

// File: tb/tb_demosaic_timing_ctrl.sv
// tb_demosaic_timing_ctrl: directed and random frames against a pixel-tagging reference model,
// one DUT with default counters and one with 4-bit counters sharing the same stimulus.
module tb_demosaic_timing_ctrl;
  localparam int L = 3;
  localparam int P = 1;
  logic clock = 0, reset = 1;
  logic [1:0] cfg_pattern = 0;
  logic vs_i = 0, hs_i = 0, de_i = 0;
  logic aclr_w[2], clken_w[2], lp_w[2], pp_w[2], vso_w[2], hso_w[2], deo_w[2], err_w[2], done_w[2];
  logic [11:0] lc0, pc0;
  logic [3:0] lc1, pc1;
  int tests = 0, fails = 0;
  int n_deo = 0, n_clk = 0, n_done = 0;
  bit q_pp[$], q_lp[$];
  always #5 clock = ~clock;
  demosaic_timing_ctrl #(.LATENCY(L), .PRIME_LINES(P), .CNT_W(12)) u_big (
    .clock(clock), .reset(reset), .cfg_pattern(cfg_pattern), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .buf_aclr(aclr_w[0]), .buf_clken(clken_w[0]), .line_phase(lp_w[0]), .pixel_phase(pp_w[0]),
    .vs_o(vso_w[0]), .hs_o(hso_w[0]), .de_o(deo_w[0]), .line_cnt(lc0), .pix_cnt(pc0),
    .width_err(err_w[0]), .frame_done(done_w[0]));
  demosaic_timing_ctrl #(.LATENCY(L), .PRIME_LINES(P), .CNT_W(4)) u_small (
    .clock(clock), .reset(reset), .cfg_pattern(cfg_pattern), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .buf_aclr(aclr_w[1]), .buf_clken(clken_w[1]), .line_phase(lp_w[1]), .pixel_phase(pp_w[1]),
    .vs_o(vso_w[1]), .hs_o(hso_w[1]), .de_o(deo_w[1]), .line_cnt(lc1), .pix_cnt(pc1),
    .width_err(err_w[1]), .frame_done(done_w[1]));
  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, i, a, e, $time);
    end
  endtask
  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction
  // Reference model: every input cycle is tagged with its column, line-in-frame and pass/mask,
  // and the tags emerge L cycles later; counters are plain ints clipped to the counter range.
  int maxc[2] = '{4095, 15};
  bit m_vsp, m_dep, m_inf, m_done;
  logic [1:0] m_pat;
  int m_tl, m_run;
  int m_idx[2], m_lines[2], m_ref[2];
  bit m_err[2];
  bit h_de[L], h_vs[L], h_hs[L], h_pass[L];
  int h_col[L], h_line[L];
  always @(posedge clock) begin
    if (reset) begin
      m_vsp = 0; m_dep = 0; m_inf = 0; m_done = 0; m_pat = 0; m_tl = 0; m_run = 0;
      for (int i = 0; i < 2; i++) begin
        m_idx[i] = 0; m_lines[i] = 0; m_ref[i] = -1; m_err[i] = 0;
      end
      for (int k = 0; k < L; k++) begin
        h_de[k] = 0; h_vs[k] = 0; h_hs[k] = 0; h_pass[k] = 0; h_col[k] = 0; h_line[k] = 0;
      end
    end else begin
      bit vsr, eol, pass;
      int w;
      vsr = vs_i && !m_vsp;
      eol = m_dep && !de_i;
      pass = m_inf && m_lines[0] >= P;
      m_run = de_i ? (m_dep ? m_run + 1 : 0) : 0;
      for (int k = L - 1; k > 0; k--) begin
        h_de[k] = h_de[k-1]; h_vs[k] = h_vs[k-1]; h_hs[k] = h_hs[k-1];
        h_pass[k] = h_pass[k-1]; h_col[k] = h_col[k-1]; h_line[k] = h_line[k-1];
      end
      h_de[0] = de_i; h_vs[0] = vs_i; h_hs[0] = hs_i; h_pass[0] = pass;
      h_col[0] = m_run; h_line[0] = vsr ? 0 : m_tl;
      m_done = vsr && (pass || m_lines[0] != 0);
      if (vsr) begin
        m_tl = 0; m_pat = cfg_pattern; m_inf = 1;
        for (int i = 0; i < 2; i++) begin
          m_idx[i] = 0; m_lines[i] = 0; m_ref[i] = -1; m_err[i] = 0;
        end
      end else begin
        if (eol) m_tl++;
        if (m_inf) for (int i = 0; i < 2; i++) begin
          if (eol) begin
            w = mn(m_idx[i], maxc[i]) + 1;
            m_lines[i]++;
            if (m_ref[i] < 0) m_ref[i] = w;
            else if (w != m_ref[i]) m_err[i] = 1;
          end
          if (de_i && m_dep) begin
            m_idx[i]++;
            if (m_idx[i] > maxc[i]) m_err[i] = 1;
          end else m_idx[i] = 0;
        end
      end
      m_vsp = vs_i;
      m_dep = de_i;
    end
  end
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      bit e_de;
      e_de = h_de[L-1] && h_pass[L-1];
      chk("de_o", i, deo_w[i], e_de);
      chk("vs_o", i, vso_w[i], h_vs[L-1]);
      chk("hs_o", i, hso_w[i], h_hs[L-1]);
      chk("buf_aclr", i, aclr_w[i], vs_i && !m_vsp);
      chk("buf_clken", i, clken_w[i], de_i && m_inf);
      chk("line_cnt", i, i == 0 ? {20'b0, lc0} : {28'b0, lc1}, mn(m_lines[i], maxc[i]));
      chk("pix_cnt", i, i == 0 ? {20'b0, pc0} : {28'b0, pc1}, mn(m_idx[i], maxc[i]));
      chk("width_err", i, err_w[i], m_err[i]);
      chk("frame_done", i, done_w[i], m_done);
      if (e_de) begin
        chk("pixel_phase", i, pp_w[i], m_pat[0] ^ h_col[L-1][0]);
        chk("line_phase", i, lp_w[i], m_pat[1] ^ h_line[L-1][0]);
      end
    end
    if (deo_w[0]) begin
      n_deo++;
      q_pp.push_back(pp_w[0]);
      q_lp.push_back(lp_w[0]);
    end
    if (clken_w[0]) n_clk++;
    if (done_w[0]) n_done++;
  end
  task automatic step(input bit v, input bit h, input bit d);
    vs_i = v; hs_i = h; de_i = d;
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  task automatic line(input int n);
    step(0, 1, 0);
    step(0, 0, 0);
    repeat (n) step(0, 0, 1);
    step(0, 0, 0);
  endtask
  task automatic vsync(input logic [1:0] c);
    cfg_pattern = c;
    idle(L + 2);
    step(1, 0, 0);
    step(1, 0, 0);
    idle(2);
  endtask
  task automatic vs_line(input logic [1:0] c, input int n);
    cfg_pattern = c;
    idle(L + 2);
    step(1, 0, 1);
    step(1, 0, 1);
    repeat (n - 2) step(0, 0, 1);
    step(0, 0, 0);
  endtask
  task automatic reset_line(input int n);
    step(0, 1, 0);
    step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    reset = 1;
    step(0, 0, 1);
    step(0, 0, 1);
    reset = 0;
    repeat (n) step(0, 0, 1);
    step(0, 0, 0);
  endtask
  initial begin
    repeat (2) step(0, 0, 1);
    step(0, 0, 0);
    reset = 0;
    repeat (5) step(0, 0, 1);
    chk("idle_pix", 0, pc0, 0);
    step(0, 0, 0);
    repeat (2) line(8);
    chk("idle_deo_cnt", 0, n_deo, 0);
    chk("idle_clken_cnt", 0, n_clk, 0);
    chk("idle_line_cnt", 0, lc0, 0);
    n_deo = 0; n_done = 0;
    vsync(0);
    line(8);
    line(8);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("lat_c1", 0, deo_w[0], 0);
    step(0, 0, 1);
    chk("lat_c2", 0, deo_w[0], 0);
    step(0, 0, 1);
    chk("lat_c3", 0, deo_w[0], 1);
    repeat (5) step(0, 0, 1);
    step(0, 0, 0);
    line(8);
    idle(L + 2);
    chk("frame_deo_cnt", 0, n_deo, 24);
    vsync(3);
    chk("frame_done_cnt", 0, n_done, 1);
    q_pp.delete();
    q_lp.delete();
    repeat (4) line(8);
    idle(L + 2);
    chk("ph_cnt", 0, q_pp.size(), 24);
    if (q_pp.size() >= 24) begin
      chk("pp0", 0, q_pp[0], 1);
      chk("pp1", 0, q_pp[1], 0);
      chk("pp2", 0, q_pp[2], 1);
      chk("lp_line1", 0, q_lp[0], 0);
      chk("lp_line2", 0, q_lp[8], 1);
      chk("lp_line3", 0, q_lp[16], 0);
    end
    vsync(0);
    line(8);
    line(8);
    line(7);
    chk("short_err", 0, err_w[0], 1);
    line(8);
    chk("short_err_hold", 0, err_w[0], 1);
    idle(L + 2);
    vs_i = 1; hs_i = 0; de_i = 1;
    #1;
    chk("vsde_aclr", 0, aclr_w[0], 1);
    @(posedge clock);
    #1;
    chk("vsde_line", 0, lc0, 0);
    chk("vsde_pix", 0, pc0, 0);
    chk("vsde_done", 0, done_w[0], 1);
    chk("vsde_err_clr", 0, err_w[0], 0);
    step(1, 0, 1);
    repeat (6) step(0, 0, 1);
    step(0, 0, 0);
    line(8);
    line(8);
    vsync(1);
    step(0, 1, 0);
    step(0, 0, 0);
    repeat (20) step(0, 0, 1);
    chk("sat_pix", 1, pc1, 15);
    chk("sat_err", 1, err_w[1], 1);
    chk("wide_pix", 0, pc0, 19);
    chk("wide_err", 0, err_w[0], 0);
    step(0, 0, 0);
    line(20);
    line(20);
    for (int f = 0; f < 40; f++) begin
      logic [1:0] c;
      int nl, w, r;
      c = 2'($urandom_range(0, 3));
      nl = $urandom_range(1, 5);
      w = $urandom_range(3, 20);
      if ($urandom_range(0, 5) == 0) vs_line(c, w);
      else vsync(c);
      for (int k = 0; k < nl; k++) begin
        r = $urandom_range(0, 11);
        if (r == 0) reset_line(w - 5);
        else line(r == 1 ? w - 1 : w);
        idle($urandom_range(0, 3));
      end
    end
    idle(L + 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
